exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_stage_pkg.sv | 23 ++
 rtl/exec_mul4.sv | 86 ++++++++
 rtl/exec_stage.sv | 185 ++++++++++++++++++
 tb/tb_exec_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_stage_pkg.sv
// -----------------------------------------------------------------------------
// exec_stage_pkg
// Shared definitions for the execute stage and its serial multiplier:
// default operand/accumulator widths, the 2-bit opcode encoding and the
// three-state control FSM encoding.
// -----------------------------------------------------------------------------
package exec_stage_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ACC_W_DEF  = 2 * DATA_W_DEF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/exec_mul4.sv
// -----------------------------------------------------------------------------
// exec_mul4
// Unsigned LSB-first serial shift-add multiplier. One multiplier bit is
// consumed per clock edge while busy, so a product takes DATA_W edges after
// the start edge.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-low reset (aborts any product in flight)
//   start_i    : load operands and begin a new product on this edge
//   a_i, b_i   : multiplicand / multiplier, sampled only when start_i is high
//   done_o     : high during the final step; product_o is complete then
//   product_o  : running product including the current step (exact, ACC_W)
// -----------------------------------------------------------------------------
module exec_mul4
    import exec_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [ACC_W-1:0]  product_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic              busy_q,   busy_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [ACC_W-1:0]  mcand_q,  mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [ACC_W-1:0]  prod_q,   prod_d;
    logic [ACC_W-1:0]  step_sum;

    // Partial product for the bit currently at mplier_q[0]; exposing it
    // directly lets the consumer use the finished product on the last edge.
    assign step_sum  = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign product_o = step_sum;
    assign done_o    = busy_q && (cnt_q == CNT_LAST);

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{(ACC_W-DATA_W){1'b0}}, a_i};
            mplier_d = b_i;
            prod_d   = '0;
        end else if (busy_q) begin
            prod_d   = step_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// -----------------------------------------------------------------------------
// exec_stage
// Single-issue execute stage with valid/ready handshakes on both sides.
// ADD/SUB/AND complete on the accepting edge; MUL runs through the serial
// multiplier for DATA_W edges. Results may be summed into an accumulator.
//
// Ports
//   clk, reset          : clock (rising edge), synchronous active-low reset
//   in_valid / in_ready : upstream handshake
//   ctrl1               : accumulate enable (latched on accept)
//   ctrl2               : opcode 00 ADD, 01 SUB, 10 MUL, 11 AND
//   data1, data2        : operands A and B (DATA_W each)
//   acc_clr             : synchronous accumulator clear, wins over any write
//   out_valid/out_ready : downstream handshake
//   result, carry, zero : registered result and flags, held while stalled
//   acc                 : accumulator register
// -----------------------------------------------------------------------------
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = 2 * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ctrl1,
    input  logic [1:0]        ctrl2,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              carry,
    output logic              zero,
    output logic [ACC_W-1:0]  acc
);

    state_e            state_q, state_d;
    logic              acc_en_q, acc_en_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    logic              accept;
    logic              is_mul_in;
    logic              mul_start;
    logic              mul_done;
    logic [ACC_W-1:0]  mul_prod;
    logic [ACC_W-1:0]  alu_res;
    logic [ACC_W-1:0]  op_res;
    logic [ACC_W:0]    sum;
    logic              finish;
    logic              fin_acc_en;

    function automatic logic [ACC_W-1:0] alu_op(input logic [1:0]        op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [ACC_W-1:0] ax;
        logic [ACC_W-1:0] bx;
        ax = {{(ACC_W-DATA_W){1'b0}}, a};
        bx = {{(ACC_W-DATA_W){1'b0}}, b};
        case (op)
            OP_ADD:  return ax + bx;
            OP_SUB:  return ax - bx;
            OP_AND:  return ax & bx;
            default: return '0;
        endcase
    endfunction

    assign accept    = in_valid && in_ready;
    assign is_mul_in = (ctrl2 == OP_MUL);
    assign mul_start = accept && is_mul_in;

    exec_mul4 #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (data1),
        .b_i       (data2),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = is_mul_in ? BUSY : DONE;
            end
            BUSY: begin
                if (mul_done) state_d = DONE;
            end
            DONE: begin
                // A new operation can be taken on the same edge the old
                // result is consumed, avoiding an IDLE bubble.
                if (out_ready) begin
                    if (accept) state_d = is_mul_in ? BUSY : DONE;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready = reset;
            DONE: begin
                in_ready  = reset && out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Result path: an ALU op finishes on its accept edge, a MUL on its last step.
    assign alu_res    = alu_op(ctrl2, data1, data2);
    assign op_res     = (state_q == BUSY) ? mul_prod : alu_res;
    assign finish     = (accept && !is_mul_in) || ((state_q == BUSY) && mul_done);
    assign fin_acc_en = accept ? ctrl1 : acc_en_q;
    assign sum        = {1'b0, acc_q} + {1'b0, op_res};

    always_comb begin
        acc_en_d = accept ? ctrl1 : acc_en_q;
        acc_d    = acc_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        if (finish) begin
            if (fin_acc_en) begin
                result_d = sum[ACC_W-1:0];
                carry_d  = sum[ACC_W];
                acc_d    = sum[ACC_W-1:0];
            end else begin
                result_d = op_res;
                carry_d  = 1'b0;
            end
            zero_d = (result_d == '0);
        end
        // Clear beats the accumulate write; result still shows the sum.
        if (acc_clr) acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_en_q <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            acc_en_q <= acc_en_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign acc    = acc_q;

endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 8;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] AND = 2'b11;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              ctrl1;
    logic [1:0]        ctrl2;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              acc_clr;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  result;
    logic              carry;
    logic              zero;
    logic [ACC_W-1:0]  acc;

    int checks = 0;
    int errors = 0;
    int seen_valid;

    exec_stage #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl1     (ctrl1),
        .ctrl2     (ctrl2),
        .data1     (data1),
        .data2     (data2),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .acc       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present one operation at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic c1, input logic [1:0] op,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        ctrl1    = c1;
        ctrl2    = op;
        data1    = a;
        data2    = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        ctrl1     = 1'b0;
        ctrl2     = ADD;
        data1     = '0;
        data2     = '0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_result",    32'(result),    32'h0);
        check("rst_carry",     32'(carry),     32'h0);
        check("rst_zero",      32'(zero),      32'h0);
        check("rst_acc",       32'(acc),       32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        reset = 1'b1;
        #1;
        check("rel_in_ready",  32'(in_ready),  32'h1);

        // ADD 9+8, no accumulate, latency 1
        send(1'b0, ADD, 4'h9, 4'h8);
        check("add_out_valid", 32'(out_valid), 32'h1);
        check("add_result",    32'(result),    32'h11);
        check("add_carry",     32'(carry),     32'h0);
        check("add_zero",      32'(zero),      32'h0);
        check("add_acc",       32'(acc),       32'h0);
        @(negedge clk);
        check("add_drain",     32'(out_valid), 32'h0);

        // Build acc = 0x20 with two accumulating ADDs (back-to-back)
        send(1'b1, ADD, 4'hF, 4'hF);
        check("acc1_result",   32'(result),    32'h1E);
        check("acc1_acc",      32'(acc),       32'h1E);
        send(1'b1, ADD, 4'h1, 4'h1);
        check("acc2_result",   32'(result),    32'h20);
        check("acc2_acc",      32'(acc),       32'h20);
        check("acc2_carry",    32'(carry),     32'h0);
        @(negedge clk);

        // MUL 15*15 + 0x20 = 0x101 -> result 0x01, carry 1
        out_ready = 1'b0;
        send(1'b1, MUL, 4'hF, 4'hF);
        ctrl1    = 1'b0;
        ctrl2    = ADD;
        data1    = 4'h0;
        data2    = 4'h0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mul_busy_in_ready",  32'(in_ready),  32'h0);
            check("mul_busy_out_valid", 32'(out_valid), 32'h0);
            @(negedge clk);
        end
        check("mul_out_valid", 32'(out_valid), 32'h1);
        check("mul_result",    32'(result),    32'h01);
        check("mul_carry",     32'(carry),     32'h1);
        check("mul_zero",      32'(zero),      32'h0);
        check("mul_acc",       32'(acc),       32'h01);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mul_drain",     32'(out_valid), 32'h0);

        // SUB 3-5 stalled for 3 cycles, then AND accepted on the consume edge
        out_ready = 1'b0;
        send(1'b0, SUB, 4'h3, 4'h5);
        check("sub_result",    32'(result),    32'hFE);
        check("sub_carry",     32'(carry),     32'h0);
        for (int i = 0; i < 3; i++) begin
            data1 = 4'(i + 7);
            data2 = 4'(i + 2);
            @(negedge clk);
            check("sub_hold_valid",  32'(out_valid), 32'h1);
            check("sub_hold_result", 32'(result),    32'hFE);
            check("sub_hold_zero",   32'(zero),      32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("done_in_ready", 32'(in_ready),  32'h1);
        send(1'b0, AND, 4'hC, 4'h3);
        check("and_out_valid", 32'(out_valid), 32'h1);
        check("and_result",    32'(result),    32'h00);
        check("and_zero",      32'(zero),      32'h1);
        check("and_carry",     32'(carry),     32'h0);
        check("and_acc",       32'(acc),       32'h01);
        @(negedge clk);

        // Reset in the 2nd BUSY cycle of a MUL: everything dropped
        send(1'b1, MUL, 4'h3, 4'h5);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("abort_out_valid", 32'(out_valid), 32'h0);
        check("abort_result",    32'(result),    32'h0);
        check("abort_acc",       32'(acc),       32'h0);
        check("abort_carry",     32'(carry),     32'h0);
        check("abort_zero",      32'(zero),      32'h0);
        check("abort_in_ready",  32'(in_ready),  32'h0);
        reset = 1'b1;
        #1;
        check("abort_rel_ready", 32'(in_ready),  32'h1);
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen_valid++;
        end
        check("abort_no_result", 32'(seen_valid), 32'h0);

        // Fresh MUL after the abort: 3*5 = 0x0F, no accumulate
        send(1'b0, MUL, 4'h3, 4'h5);
        repeat (3) @(negedge clk);
        check("mul2_busy",      32'(out_valid), 32'h0);
        @(negedge clk);
        check("mul2_out_valid", 32'(out_valid), 32'h1);
        check("mul2_result",    32'(result),    32'h0F);
        check("mul2_acc",       32'(acc),       32'h00);
        check("mul2_carry",     32'(carry),     32'h0);

        // acc_clr coinciding with an accumulate write
        send(1'b1, ADD, 4'h8, 4'h8);
        check("pre_clr_acc",    32'(acc),       32'h10);
        acc_clr = 1'b1;
        send(1'b1, ADD, 4'h1, 4'h1);
        acc_clr = 1'b0;
        check("clr_result",     32'(result),    32'h12);
        check("clr_acc",        32'(acc),       32'h00);
        check("clr_carry",      32'(carry),     32'h0);

        // acc_clr while idle
        send(1'b1, ADD, 4'h2, 4'h3);
        check("acc5_acc",       32'(acc),       32'h05);
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("idle_clr_acc",    32'(acc),       32'h00);
        check("idle_clr_result", 32'(result),    32'h05);
        check("idle_out_valid",  32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
